// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller and its helpers.
// Holds opcode/funct constants, ALU op codes, the FSM state encoding, datapath
// select codes, fault codes and the control-strobe bundle.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned FAULT_W  = 2;
    localparam int unsigned INSTR_W  = 32;

    // Opcodes, instruction[31:26]
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2b;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 6'h3f;

    // R-type funct field, instruction[5:0]
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2a;

    // ALU operation codes
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd6;

    // FSM state encoding; 3'd7 is unused and recovers to FETCH
    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    // Next-PC select
    localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

    // ALU operand selects
    localparam logic ALU_A_PC = 1'b0;
    localparam logic ALU_A_RS = 1'b1;

    localparam logic [SEL_W-1:0] ALU_B_RT      = 2'b00;
    localparam logic [SEL_W-1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] ALU_B_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] ALU_B_IMM_SH2 = 2'b11;

    // Fault codes
    localparam logic [FAULT_W-1:0] FAULT_NONE    = 2'b00;
    localparam logic [FAULT_W-1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [FAULT_W-1:0] FAULT_TIMEOUT = 2'b10;

    // Datapath control strobes (alu_op is produced by alu_op_decode)
    typedef struct packed {
        logic             mem_read;
        logic             mem_write;
        logic             iord;
        logic             ir_write;
        logic             pc_write;
        logic             pc_write_cond;
        logic [SEL_W-1:0] pc_src;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic             reg_write;
        logic             reg_dst;
        logic             mem_reg;
    } ctrl_t;

    // True for instructions that proceed from DECODE into EXEC
    function automatic logic is_exec_legal(input logic [OPCODE_W-1:0] opcode,
                                           input logic [FUNCT_W-1:0]  funct);
        logic legal;
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SLT);
            OP_BEQ, OP_LW, OP_SW, OP_ADDI, OP_J: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// ALU operation decode shared by the multi-cycle and pipelined control.
// Ports:
//   state_i  : current controller state
//   opcode_i : instruction opcode field
//   funct_i  : R-type funct field
//   alu_op_o : ALU operation (add / slt / sub)
module alu_op_decode
    import cpu_pkg::*;
(
    input  state_e                state_i,
    input  logic [OPCODE_W-1:0]   opcode_i,
    input  logic [FUNCT_W-1:0]    funct_i,
    output logic [ALU_OP_W-1:0]   alu_op_o
);

    // Only EXEC does anything other than add (PC+4, branch target, address calc)
    always_comb begin
        alu_op_o = ALU_ADD;
        if (state_i == ST_EXEC) begin
            case (opcode_i)
                OP_RTYPE: if (funct_i == FN_SLT) alu_op_o = ALU_SLT;
                OP_BEQ:   alu_op_o = ALU_SUB;
                default:  alu_op_o = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the MIPS-subset datapath (add, slt, beq, lw, sw,
// addi, j, halt). Steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// stalls on mem_ready and traps on illegal instructions or memory timeout.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   instruction       : current IR contents
//   mem_ready         : memory completes the requested access this cycle
//   alu_zero          : ALU zero flag (consumed by datapath PC-write gating)
//   mem_read/write    : memory request strobes
//   iord              : memory address select (0 PC, 1 ALUOut)
//   ir_write          : IR load
//   pc_write(_cond)   : PC load, unconditional / qualified by alu_zero
//   pc_src            : next-PC select
//   alu_src_a/b,alu_op: ALU operand selects and operation
//   reg_write,reg_dst : register file write enable / destination select
//   mem_reg           : writeback source select
//   halted, fault     : terminal status
//   state             : current state for debug
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INSTR_W-1:0]   instruction,
    input  logic                 mem_ready,
    input  logic                 alu_zero,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [SEL_W-1:0]     pc_src,
    output logic                 alu_src_a,
    output logic [SEL_W-1:0]     alu_src_b,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_reg,
    output logic                 halted,
    output logic [FAULT_W-1:0]   fault,
    output logic [STATE_W-1:0]   state
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    state_e               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [FAULT_W-1:0]   fault_q, fault_d;
    logic [WAIT_W-1:0]    wait_inc;
    logic                 wait_expired;
    logic [OPCODE_W-1:0]  opcode;
    logic [FUNCT_W-1:0]   funct;
    ctrl_t                ctrl_c;
    logic                 unused_c;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];

    // alu_zero is applied by the datapath to pc_write_cond; the middle IR
    // fields are datapath-only as well
    assign unused_c = ^{alu_zero, instruction[25:6]};

    // The wait that would make this the MAX_WAIT-th not-ready cycle times out;
    // mem_ready in that same cycle still wins
    assign wait_inc     = wait_q + WAIT_W'(1);
    assign wait_expired = !mem_ready && (wait_inc == WAIT_W'(MAX_WAIT));

    // State, wait counter and sticky fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    // Next-state, wait counter and fault update
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        fault_d = fault_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (is_exec_legal(opcode, funct)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI: state_d = ST_WB;
                    OP_LW, OP_SW:      state_d = ST_MEM;
                    default:           state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (opcode == OP_LW) ? ST_WB : ST_FETCH;
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_WB:    state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Per-state datapath control; everything not set here stays 0
    always_comb begin
        ctrl_c = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.iord      = 1'b0;
                ctrl_c.alu_src_a = ALU_A_PC;
                ctrl_c.alu_src_b = ALU_B_FOUR;
                ctrl_c.pc_src    = PC_SRC_ALU;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl_c.alu_src_a = ALU_A_PC;
                ctrl_c.alu_src_b = ALU_B_IMM_SH2;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        ctrl_c.alu_src_a = ALU_A_RS;
                        ctrl_c.alu_src_b = ALU_B_RT;
                    end
                    OP_LW, OP_SW, OP_ADDI: begin
                        ctrl_c.alu_src_a = ALU_A_RS;
                        ctrl_c.alu_src_b = ALU_B_IMM;
                    end
                    OP_BEQ: begin
                        ctrl_c.alu_src_a     = ALU_A_RS;
                        ctrl_c.alu_src_b     = ALU_B_RT;
                        ctrl_c.pc_write_cond = 1'b1;
                        ctrl_c.pc_src        = PC_SRC_ALUOUT;
                    end
                    OP_J: begin
                        ctrl_c.pc_write = 1'b1;
                        ctrl_c.pc_src   = PC_SRC_JUMP;
                    end
                    default: ctrl_c = '0;
                endcase
            end
            ST_MEM: begin
                ctrl_c.iord      = 1'b1;
                ctrl_c.mem_read  = (opcode == OP_LW);
                ctrl_c.mem_write = (opcode == OP_SW);
            end
            ST_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = (opcode == OP_RTYPE);
                ctrl_c.mem_reg   = (opcode == OP_LW);
            end
            default: ctrl_c = '0;
        endcase
    end

    alu_op_decode u_alu_op_decode (
        .state_i  (state_q),
        .opcode_i (opcode),
        .funct_i  (funct),
        .alu_op_o (alu_op)
    );

    assign mem_read      = ctrl_c.mem_read;
    assign mem_write     = ctrl_c.mem_write;
    assign iord          = ctrl_c.iord;
    assign ir_write      = ctrl_c.ir_write;
    assign pc_write      = ctrl_c.pc_write;
    assign pc_write_cond = ctrl_c.pc_write_cond;
    assign pc_src        = ctrl_c.pc_src;
    assign alu_src_a     = ctrl_c.alu_src_a;
    assign alu_src_b     = ctrl_c.alu_src_b;
    assign reg_write     = ctrl_c.reg_write;
    assign reg_dst       = ctrl_c.reg_dst;
    assign mem_reg       = ctrl_c.mem_reg;
    assign halted        = (state_q == ST_HALT);
    assign fault         = fault_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction sequences with literal
// expectations, plus a per-cycle comparison against an instruction-level model.
module tb_multicycle_controller;

    localparam int unsigned MAX_WAIT = 15;

    localparam logic [31:0] I_ADD  = 32'h00A62020;
    localparam logic [31:0] I_SLT  = 32'h00A6202A;
    localparam logic [31:0] I_SUB  = 32'h00A62022;
    localparam logic [31:0] I_LW   = 32'h8C820004;
    localparam logic [31:0] I_SW   = 32'hAC820004;
    localparam logic [31:0] I_BEQ  = 32'h10850003;
    localparam logic [31:0] I_ADDI = 32'h20A50001;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_HALT = 32'hFC000000;
    localparam logic [31:0] I_ILL  = 32'h44000000;

    localparam int C_ADD = 0, C_SLT = 1, C_LW = 2, C_SW = 3, C_ADDI = 4;
    localparam int C_BEQ = 5, C_J = 6, C_HALT = 7, C_ILL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        alu_zero;
    logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        reg_write, reg_dst, mem_reg, halted;
    logic [1:0]  fault;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .mem_ready     (mem_ready),
        .alu_zero      (alu_zero),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_reg       (mem_reg),
        .halted        (halted),
        .fault         (fault),
        .state         (state)
    );

    task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instruction-level model ----------------
    function automatic int cls_of(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00 && fn == 6'h20) return C_ADD;
        if (op == 6'h00 && fn == 6'h2a) return C_SLT;
        if (op == 6'h23) return C_LW;
        if (op == 6'h2b) return C_SW;
        if (op == 6'h08) return C_ADDI;
        if (op == 6'h04) return C_BEQ;
        if (op == 6'h02) return C_J;
        if (op == 6'h3f) return C_HALT;
        return C_ILL;
    endfunction

    // Expected output vector for a phase of an instruction class
    function automatic logic [22:0] model_out(input int st, input logic [31:0] ins,
                                              input logic rdy, input int flt);
        int c;
        logic mr, mw, io, irw, pw, pwc, asa, rw, rd, mrg, hl;
        logic [1:0] ps, asb;
        logic [2:0] aop;
        c = cls_of(ins);
        {mr, mw, io, irw, pw, pwc, asa, rw, rd, mrg, hl} = '0;
        ps = '0; asb = '0; aop = '0;
        case (st)
            0: begin mr = 1'b1; asb = 2'd1; irw = rdy; pw = rdy; end
            1: asb = 2'd3;
            2: begin
                if (c == C_ADD || c == C_SLT) begin
                    asa = 1'b1; aop = (c == C_SLT) ? 3'd4 : 3'd0;
                end else if (c == C_LW || c == C_SW || c == C_ADDI) begin
                    asa = 1'b1; asb = 2'd2;
                end else if (c == C_BEQ) begin
                    asa = 1'b1; aop = 3'd6; pwc = 1'b1; ps = 2'd1;
                end else if (c == C_J) begin
                    pw = 1'b1; ps = 2'd2;
                end
            end
            3: begin io = 1'b1; mr = (c == C_LW); mw = (c == C_SW); end
            4: begin rw = 1'b1; rd = (c == C_ADD || c == C_SLT); mrg = (c == C_LW); end
            5: hl = 1'b1;
            default: ;
        endcase
        return {mr, mw, io, irw, pw, pwc, ps, asa, asb, aop, rw, rd, mrg, hl, 2'(flt), 3'(st)};
    endfunction

    int m_st = 0, m_wait = 0, m_fault = 0;
    bit m_valid = 1'b0;

    // Advance the model one cycle from the values seen at the edge
    always @(posedge clk) begin
        int c;
        int nxt;
        c = cls_of(instruction);
        if (rst) begin
            m_st = 0; m_wait = 0; m_fault = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            nxt = m_st;
            case (m_st)
                0, 3: begin
                    if (mem_ready)
                        nxt = (m_st == 0) ? 1 : ((c == C_LW) ? 4 : 0);
                    else if (m_wait + 1 == int'(MAX_WAIT)) begin
                        nxt = 6; m_fault = 2;
                    end else
                        m_wait = m_wait + 1;
                end
                1: begin
                    if (c == C_HALT) nxt = 5;
                    else if (c == C_ILL) begin nxt = 6; m_fault = 1; end
                    else nxt = 2;
                end
                2: begin
                    if (c == C_ADD || c == C_SLT || c == C_ADDI) nxt = 4;
                    else if (c == C_LW || c == C_SW) nxt = 3;
                    else nxt = 0;
                end
                4: nxt = 0;
                default: nxt = m_st;
            endcase
            if (mem_ready || nxt != m_st) m_wait = 0;
            m_st = nxt;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [22:0] exp_v, act_v;
        if (m_valid) begin
            exp_v = model_out(m_st, instruction, mem_ready, m_fault);
            act_v = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
                     alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_reg, halted,
                     fault, state};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_outputs at %0t: got %06h expected %06h", $time, act_v, exp_v);
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; mem_ready = 1'b1; alu_zero = 1'b0; instruction = I_ADD;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // first post-reset cycle
        smp;
        ck("rst_state", state, 0); ck("rst_fault", fault, 0); ck("rst_halted", halted, 0);
        ck("rst_mem_read", mem_read, 1); ck("rst_iord", iord, 0); ck("rst_ir_write", ir_write, 1);

        // add: F D E W
        adv; smp; ck("add_D", state, 1); ck("add_D_srcb", alu_src_b, 3);
        adv; smp; ck("add_E", state, 2); ck("add_E_aluop", alu_op, 0); ck("add_E_srca", alu_src_a, 1);
        adv; smp; ck("add_W", state, 4); ck("add_W_rw", reg_write, 1); ck("add_W_rd", reg_dst, 1);
        adv; instruction = I_LW; smp; ck("add_done", state, 0);

        // lw with 3 wait cycles in MEM
        adv; smp; ck("lw_D", state, 1);
        adv; smp; ck("lw_E", state, 2); ck("lw_E_srcb", alu_src_b, 2);
        adv; mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1'b1;
            smp; ck("lw_M", state, 3); ck("lw_M_rd", mem_read, 1); ck("lw_M_iord", iord, 1);
            adv;
        end
        smp; ck("lw_W", state, 4); ck("lw_W_mreg", mem_reg, 1); ck("lw_W_rw", reg_write, 1);
        ck("lw_W_rdst", reg_dst, 0);
        adv; instruction = I_BEQ; alu_zero = 1'b1; smp; ck("lw_done", state, 0);

        // beq taken: F D E then FETCH
        adv; smp; ck("beq_D", state, 1);
        adv; smp; ck("beq_E", state, 2); ck("beq_aluop", alu_op, 6);
        ck("beq_pwc", pc_write_cond, 1); ck("beq_pcsrc", pc_src, 1);
        adv; instruction = I_SW; alu_zero = 1'b0; smp; ck("beq_done", state, 0);

        // sw
        adv; smp; ck("sw_D", state, 1);
        adv; smp; ck("sw_E", state, 2);
        adv; smp; ck("sw_M", state, 3); ck("sw_M_wr", mem_write, 1); ck("sw_M_rd", mem_read, 0);
        adv; instruction = I_ADDI; smp; ck("sw_done", state, 0);

        // addi
        adv; smp; ck("addi_D", state, 1);
        adv; smp; ck("addi_E_srcb", alu_src_b, 2);
        adv; smp; ck("addi_W", state, 4); ck("addi_W_rdst", reg_dst, 0);
        adv; instruction = I_SLT; smp; ck("addi_done", state, 0);

        // slt
        adv; smp; ck("slt_D", state, 1);
        adv; smp; ck("slt_E_aluop", alu_op, 4);
        adv; smp; ck("slt_W", state, 4);
        adv; instruction = I_J; smp; ck("slt_done", state, 0);

        // j
        adv; smp; ck("j_D", state, 1);
        adv; smp; ck("j_E_pw", pc_write, 1); ck("j_E_pcsrc", pc_src, 2);
        adv; instruction = I_SUB; smp; ck("j_done", state, 0);

        // R-type with unsupported funct
        adv; smp; ck("sub_D", state, 1);
        adv; smp; ck("sub_fault_state", state, 6); ck("sub_fault", fault, 1);
        adv; rst = 1'b1; smp; ck("sub_sticky", fault, 1); ck("sub_no_read", mem_read, 0);
        adv; rst = 1'b0; instruction = I_ILL; smp; ck("sub_rst_state", state, 0); ck("sub_rst_fault", fault, 0);

        // illegal opcode 0x11
        adv; smp; ck("ill_D", state, 1);
        adv; smp; ck("ill_state", state, 6); ck("ill_fault", fault, 1);
        repeat (3) begin adv; smp; ck("ill_hold", state, 6); end
        adv; rst = 1'b1; smp;
        adv; rst = 1'b0; instruction = I_HALT; smp; ck("ill_rst", state, 0);

        // halt
        adv; smp; ck("halt_D", state, 1);
        adv; smp; ck("halt_state", state, 5); ck("halt_flag", halted, 1);
        repeat (3) begin adv; smp; ck("halt_hold", halted, 1); ck("halt_ir_write", ir_write, 0); end
        adv; rst = 1'b1; smp;
        adv; rst = 1'b0; instruction = I_LW; smp; ck("halt_rst", state, 0); ck("halt_rst_flag", halted, 0);

        // reset during EXEC of lw aborts it
        adv; smp; ck("abort_D", state, 1);
        adv; rst = 1'b1; smp; ck("abort_E", state, 2);
        adv; rst = 1'b0; smp; ck("abort_state", state, 0); ck("abort_rw", reg_write, 0);
        ck("abort_wr", mem_write, 0);

        // lw timeout in MEM
        adv; smp; ck("mto_D", state, 1);
        adv; smp; ck("mto_E", state, 2);
        adv; mem_ready = 1'b0;
        for (int k = 0; k < int'(MAX_WAIT); k++) begin
            smp; ck("mto_wait", state, 3);
            adv;
        end
        smp; ck("mto_state", state, 6); ck("mto_fault", fault, 2);

        // FETCH timeout
        adv; rst = 1'b1; smp;
        adv; rst = 1'b0;
        for (int k = 0; k < int'(MAX_WAIT); k++) begin
            smp; ck("fto_wait", state, 0);
            adv;
        end
        smp; ck("fto_state", state, 6); ck("fto_fault", fault, 2);

        // ready on the last allowed wait cycle wins
        adv; rst = 1'b1; smp;
        adv; rst = 1'b0;
        for (int k = 0; k < int'(MAX_WAIT); k++) begin
            if (k == int'(MAX_WAIT) - 1) mem_ready = 1'b1;
            smp; ck("edge_wait", state, 0);
            adv;
        end
        smp; ck("edge_state", state, 1); ck("edge_fault", fault, 0);
        adv; adv;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
